// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam int                   DEF_WIDTH   = 6;
    localparam logic [DEF_WIDTH-1:0] DEF_PATTERN = 6'b110011;

endpackage

// File: rtl/seq_gen_down_counter.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
module seq_gen_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load, count down (saturating at zero), or hold
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register, cleared by the active-low asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/sequence_gen_shift_reg.sv
// Serial pattern transmitter: sends PATTERN MSB first, `repeats` copies per burst.
// Define SEQ_GEN_GAP_EN to insert one idle bit between consecutive copies.
module sequence_gen_shift_reg
    import seq_gen_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN  = DEF_PATTERN,
    parameter int               REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [REPEAT_W-1:0] repeats,
    input  logic                abort,
    output logic                out_bit,
    output logic                out_valid,
    output logic                busy,
    output logic                done
);

    localparam int BIT_W = $clog2(WIDTH);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             out_bit_q;
    logic             out_bit_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             bit_load_s;
    logic             bit_dec_s;
    logic             bit_zero_s;
    logic             rep_load_s;
    logic             rep_dec_s;
    logic             rep_zero_s;

    // The bit counter holds the bits left in the current copy minus one
    seq_gen_down_counter #(.W(BIT_W)) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (bit_load_s),
        .load_val (BIT_W'(WIDTH - 1)),
        .dec      (bit_dec_s),
        .zero     (bit_zero_s)
    );

    seq_gen_down_counter #(.W(REPEAT_W)) u_rep_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (rep_load_s),
        .load_val (repeats - {{(REPEAT_W-1){1'b0}}, 1'b1}),
        .dec      (rep_dec_s),
        .zero     (rep_zero_s)
    );

    // Next-state, shift-register and counter control
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_load_s = 1'b0;
        bit_dec_s  = 1'b0;
        rep_load_s = 1'b0;
        rep_dec_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (repeats != {REPEAT_W{1'b0}}) && !abort) begin
                    state_d    = SEND;
                    shreg_d    = PATTERN;
                    bit_load_s = 1'b1;
                    rep_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                    shreg_d = {WIDTH{1'b0}};
                end else if (!bit_zero_s) begin
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_dec_s = 1'b1;
                end else if (!rep_zero_s) begin
                    shreg_d    = PATTERN;
                    bit_load_s = 1'b1;
                    rep_dec_s  = 1'b1;
`ifdef SEQ_GEN_GAP_EN
                    state_d    = GAP;
`else
                    state_d    = SEND;
`endif
                end else begin
                    state_d = DONE;
                    shreg_d = {WIDTH{1'b0}};
                end
            end
`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    shreg_d = {WIDTH{1'b0}};
                end else begin
                    state_d = SEND;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                shreg_d = {WIDTH{1'b0}};
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave straight from flops
    always_comb begin
        out_valid_d = (state_d == SEND);
        out_bit_d   = (state_d == SEND) & shreg_d[WIDTH-1];
        busy_d      = (state_d == SEND) || (state_d == GAP);
        done_d      = (state_d == DONE);
    end

    // State, shift register and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= {WIDTH{1'b0}};
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sequence_gen_shift_reg.sv
// Randomized bench for sequence_gen_shift_reg against a burst-offset reference model.
module tb_sequence_gen_shift_reg;

    localparam int W  = 6;
    localparam int RW = 4;
`ifdef SEQ_GEN_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] repeats = '0;
    logic          abort = 1'b0;
    logic          out_bit;
    logic          out_valid;
    logic          busy;
    logic          done;

    sequence_gen_shift_reg dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .repeats   (repeats),
        .abort     (abort),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] pat_v;

    // Model: a burst is described only by its copy count and the cycle offset since start
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_r      = 0;

    // Downstream detector clocked on out_valid
    logic [W-1:0] det_win = '0;
    int           det_n   = 0;
    int           det_hits = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic int burst_end();
        if (GAP_EN) return m_r * (W + 1);
        else        return m_r * W + 1;
    endfunction

    // Expected {out_valid, out_bit, busy, done} for the current cycle
    function automatic logic [3:0] exp_vec();
        int period;
        int pos;
        if (!m_active) return 4'b0000;
        if (m_t == burst_end()) return 4'b0001;
        period = GAP_EN ? (W + 1) : W;
        pos    = (m_t - 1) % period;
        if (pos >= W) return 4'b0010;
        return {1'b1, pat_v[W-1-pos], 1'b1, 1'b0};
    endfunction

    task automatic model_edge(input logic s, input logic [RW-1:0] r, input logic a);
        if (!rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (m_t == burst_end() || a) m_active = 1'b0;
            else                         m_t++;
        end else if (s && r != '0 && !a) begin
            m_active = 1'b1;
            m_t      = 1;
            m_r      = int'(r);
        end
    endtask

    task automatic clr_det();
        det_win  = '0;
        det_n    = 0;
        det_hits = 0;
    endtask

    task automatic step(input logic s, input logic [RW-1:0] r, input logic a);
        start   = s;
        repeats = r;
        abort   = a;
        @(posedge clk);
        model_edge(s, r, a);
        @(negedge clk);
        cyc++;
        start   = 1'b0;
        repeats = '0;
        abort   = 1'b0;
        chk("outs", {28'd0, out_valid, out_bit, busy, done}, {28'd0, exp_vec()});
        if (out_valid) begin
            det_win = {det_win[W-2:0], out_bit};
            det_n++;
            if (det_n >= W && det_win == pat_v) det_hits++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        pat_v = 6'b110011;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {28'd0, out_valid, out_bit, busy, done}, 32'd0);
        rst = 1'b1;
        idle(2);

        // Single copy
        clr_det();
        step(1'b1, 4'd1, 1'b0);
        idle(8);
        chk("det_single", det_hits, 32'd1);

        // Two copies
        clr_det();
        step(1'b1, 4'd2, 1'b0);
        idle(15);
        chk("det_double", det_hits, 32'd2);

        // Zero repeats, then start while busy
        step(1'b1, 4'd0, 1'b0);
        idle(2);
        clr_det();
        step(1'b1, 4'd1, 1'b0);
        idle(1);
        step(1'b1, 4'd3, 1'b0);
        idle(8);
        chk("det_busy_start", det_hits, 32'd1);

        // Abort mid-burst, then a full burst
        step(1'b1, 4'd3, 1'b0);
        idle(3);
        step(1'b0, '0, 1'b1);
        idle(1);
        clr_det();
        step(1'b1, 4'd2, 1'b0);
        idle(16);
        chk("det_after_abort", det_hits, 32'd2);

        // Start and abort together in idle
        step(1'b1, 4'd3, 1'b1);
        idle(2);

        // Asynchronous reset mid-burst
        step(1'b1, 4'd3, 1'b0);
        idle(4);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async", {28'd0, out_valid, out_bit, busy, done}, 32'd0);
        idle(2);
        rst = 1'b1;
        idle(1);
        clr_det();
        step(1'b1, 4'd1, 1'b0);
        idle(8);
        chk("det_after_rst", det_hits, 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic          s;
            logic          a;
            logic [RW-1:0] r;
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 29) == 0);
            r = RW'($urandom_range(0, 4));
            step(s, r, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
